// File: rtl/uart_rx_if.sv
// Serial receive bundle: line and baud tick into the receiver, word and status out.
// DBIT must match the receiver it is bound to.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done;
  logic            frame_err;

  modport master (
    output rx,
    output s_tick,
    input  dout,
    input  rx_done,
    input  frame_err
  );

  modport slave (
    input  rx,
    input  s_tick,
    output dout,
    output rx_done,
    output frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, DBIT data bits and SB_TICK ticks of stop bit.
// state | meaning
// IDLE  | line high, waiting for a falling edge on rx_s
// START | counting to mid start bit; a high sample there is a glitch
// DATA  | sampling one data bit every 16 ticks
// STOP  | waiting SB_TICK ticks, then publishing word and stop-bit status
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int S_MAX = (SB_TICK - 1 > 15) ? SB_TICK - 1 : 15;
  localparam int SW    = $clog2(S_MAX + 1);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic            rx_meta;
  logic            rx_s;
  logic [1:0]      state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic [DBIT-1:0] b_next;

  // Synchronizer idles high so release from reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  generate
    if (DBIT == 1) begin : g_shift_one
      assign b_next = rx_s;
    end else begin : g_shift_many
      assign b_next = {rx_s, b[DBIT-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      s             <= '0;
      n             <= '0;
      b             <= '0;
      bus.dout      <= '0;
      bus.rx_done   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s == SW'(7)) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s == SW'(15)) begin
              s <= '0;
              b <= b_next;
              if (n == NW'(DBIT - 1)) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          // A low stop sample still delivers the word, flagged as a framing error.
          if (bus.s_tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              state         <= IDLE;
              bus.dout      <= b;
              bus.frame_err <= ~rx_s;
              bus.rx_done   <= 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, corner sequences, and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic line8 = 1'b1;
  logic line7 = 1'b1;
  int   phase = 0;
  int   tick_count = 0;

  uart_rx_if #(.DBIT(8)) bus8 ();
  uart_rx_if #(.DBIT(7)) bus7 ();

  assign bus8.rx     = line8;
  assign bus8.s_tick = tick;
  assign bus7.rx     = line7;
  assign bus7.s_tick = tick;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

  always #5 clk = ~clk;

  // Baud tick: one clk in four, updated just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      phase = phase + 1;
      tick  = (phase % 4 == 0);
      if (tick) tick_count = tick_count + 1;
    end
  end

  typedef struct {
    logic [7:0] dout;
    logic       ferr;
  } frame_t;

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         stop;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  frame_t got_q[$];
  frame_t exp_q[$];
  vec_t   vecs[5];

  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    if (bus8.rx_done === 1'b1) got_q.push_back('{bus8.dout, bus8.frame_err});
  end

  // Frame-level reference: the word arrives intact, error flag is the inverted stop bit.
  function automatic frame_t model(input logic [7:0] d, input bit stop);
    frame_t f;
    f.dout = d;
    f.ferr = ~stop;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks = n_checks + 1;
    if (act < lo || act > hi) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_frames(input string name);
    int m;
    check({name, "_count"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_dout%0d", name, i), got_q[i].dout, exp_q[i].dout);
      check($sformatf("%s_ferr%0d", name, i), got_q[i].ferr, exp_q[i].ferr);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic hold8(input logic v, input int n);
    line8 = v;
    wait_ticks(n);
  endtask

  task automatic hold7(input logic v, input int n);
    line7 = v;
    wait_ticks(n);
  endtask

  // A low stop bit is cut short and followed by idle so the receiver's
  // re-armed start check lands safely on a high line.
  task automatic send8(input logic [7:0] d, input bit stop, input int gap);
    hold8(1'b0, 16);
    for (int i = 0; i < 8; i++) hold8(d[i], 16);
    if (stop) begin
      hold8(1'b1, 16);
    end else begin
      hold8(1'b0, 12);
      hold8(1'b1, 20);
    end
    if (gap > 0) hold8(1'b1, gap);
  endtask

  logic [7:0] rd;
  bit         rstop;
  int         rgap;
  logic [6:0] d7;
  int         start_tc;
  int         end_tc;
  int         w7;
  logic       done7;
  logic [6:0] dout7;
  logic       ferr7;

  initial begin
    vecs[0] = '{"a5_good",  8'hA5, 1'b1, 16, 8'hA5, 1'b0};
    vecs[1] = '{"3c_bad",   8'h3C, 1'b0, 16, 8'h3C, 1'b1};
    vecs[2] = '{"b2b_00",   8'h00, 1'b1, 0,  8'h00, 1'b0};
    vecs[3] = '{"b2b_ff",   8'hFF, 1'b1, 16, 8'hFF, 1'b0};
    vecs[4] = '{"6e_good",  8'h6E, 1'b1, 8,  8'h6E, 1'b0};

    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_dout8", bus8.dout, 8'h00);
    check("rst_done8", bus8.rx_done, 1'b0);
    check("rst_ferr8", bus8.frame_err, 1'b0);
    check("rst_dout7", bus7.dout, 7'h00);
    reset = 1'b1;
    hold8(1'b1, 20);

    for (int i = 0; i < 5; i++) begin
      send8(vecs[i].data, vecs[i].stop, vecs[i].gap);
      exp_q.push_back('{vecs[i].exp_dout, vecs[i].exp_ferr});
      check_frames(vecs[i].name);
    end

    // Short low pulse: rejected at the mid start-bit sample.
    hold8(1'b0, 4);
    hold8(1'b1, 24);
    check_frames("glitch");
    check("glitch_dout_held", bus8.dout, 8'h6E);
    check("glitch_ferr_held", bus8.frame_err, 1'b0);
    send8(8'hC3, 1'b1, 16);
    exp_q.push_back(model(8'hC3, 1'b1));
    check_frames("after_glitch");

    // Break: two full windows complete as zero words with framing errors.
    hold8(1'b0, 310);
    hold8(1'b1, 40);
    exp_q.push_back(model(8'h00, 1'b0));
    exp_q.push_back(model(8'h00, 1'b0));
    check_frames("break");

    // Reset in the middle of 0x5A, then a clean 0x81.
    rd = 8'h5A;
    hold8(1'b0, 16);
    for (int i = 0; i < 4; i++) hold8(rd[i], 16);
    reset = 1'b0;
    line8 = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_dout", bus8.dout, 8'h00);
    check("midrst_ferr", bus8.frame_err, 1'b0);
    check("midrst_done", bus8.rx_done, 1'b0);
    reset = 1'b1;
    hold8(1'b1, 32);
    send8(8'h81, 1'b1, 16);
    exp_q.push_back(model(8'h81, 1'b1));
    check_frames("reset_abort");

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        hold8(1'b0, $urandom_range(1, 4));
        hold8(1'b1, 20);
      end
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rgap  = 16 * $urandom_range(0, 2);
      send8(rd, rstop, rgap);
      exp_q.push_back(model(rd, rstop));
    end
    check_frames("random");

    // 7 data bits, two stop bits: done lands 8 + 7*16 + 32 ticks after the start edge.
    d7       = 7'h55;
    done7    = 1'b0;
    w7       = 0;
    start_tc = tick_count;
    fork
      begin
        hold7(1'b0, 16);
        for (int i = 0; i < 7; i++) hold7(d7[i], 16);
        hold7(1'b1, 32);
        hold7(1'b1, 16);
      end
      begin
        while (bus7.rx_done !== 1'b1 && w7 < 4000) begin
          @(negedge clk);
          w7 = w7 + 1;
        end
        end_tc = tick_count;
        done7  = (bus7.rx_done === 1'b1);
        dout7  = bus7.dout;
        ferr7  = bus7.frame_err;
      end
    join
    check("dbit7_done", done7, 1'b1);
    check_range("dbit7_latency", end_tc - start_tc, 152, 153);
    check("dbit7_dout", dout7, 7'h55);
    check("dbit7_ferr", ferr7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
